// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer (main + skid) and flush-to-NOP.
// Optional performance counters (stall_cnt, bubble_cnt) are built when PIPE_STATS_EN is defined.
module pipe_stage_skid #(
  parameter int DATA_W = 120,
  parameter int CTRL_W = 16,
  parameter int STAT_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                accept;
  logic                emit;

  assign in_ready  = RST_N & ~flush & (state_q != FULL);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;

  // main_ctrl is zeroed whenever the stage goes empty so an idle output is always a NOP;
  // data registers are left alone to avoid needless toggling.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = BUSY;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        BUSY: begin
          if (accept && emit) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept) begin
            state_d     = FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (emit) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
          end
        end
        FULL: begin
          if (emit) begin
            state_d     = BUSY;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; flush deliberately does not clear them.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != {STAT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    if (!out_valid_q && out_ready && (bubble_cnt_q != {STAT_W{1'b1}}))
      bubble_cnt_d = bubble_cnt_q + STAT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
